// File: rtl/me_pkg.sv
// Shared types and constants for the motion-estimator window loader.
package me_pkg;

    localparam int R_PIXELS = 256;
    localparam int S_PIXELS = 1024;
    localparam int R_AW     = 8;
    localparam int S_AW     = 10;
    localparam int TMO_W    = 13;

    localparam logic [7:0] NOT_FOUND = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_R = 3'd1,
        ST_LOAD_S = 3'd2,
        ST_RUN    = 3'd3,
        ST_OUTPUT = 3'd4
    } me_state_t;

    typedef struct packed {
        logic [7:0] best_dist;
        logic [3:0] motion_x;
        logic [3:0] motion_y;
        logic       found;
        logic       timeout;
    } me_result_t;

endpackage

// File: rtl/me_window_loader.sv
// Feeds reference and search-window pixels into the estimator memories,
// runs the estimator and hands back one result per block.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for a pixel flagged start-of-frame
// LOAD_R    | writing the 16x16 reference block into R memory
// LOAD_S    | writing the 32x32 search window into S memory
// RUN       | start held to the estimator until completed or timeout
// OUTPUT    | result presented, waiting for the consumer handshake
module me_window_loader
    import me_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int RUN_TIMEOUT = 4200
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic [DATA_W-1:0] pix_data,
    output logic              pix_ready,
    output logic              wr_r_en,
    output logic [R_AW-1:0]   wr_r_addr,
    output logic              wr_s_en,
    output logic [S_AW-1:0]   wr_s_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              me_start,
    input  logic              me_completed,
    input  logic [7:0]        me_best_dist,
    input  logic [3:0]        me_motion_x,
    input  logic [3:0]        me_motion_y,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [7:0]        res_best_dist,
    output logic [3:0]        res_motion_x,
    output logic [3:0]        res_motion_y,
    output logic              res_found,
    output logic              res_timeout,
    output logic              busy
);

    localparam logic [S_AW-1:0]  R_LAST   = S_AW'(R_PIXELS - 1);
    localparam logic [S_AW-1:0]  S_LAST   = S_AW'(S_PIXELS - 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(RUN_TIMEOUT - 1);

    me_state_t         state_q, state_d;
    logic [S_AW-1:0]   idx_q, idx_d;
    logic              pix_ready_q, pix_ready_d;
    logic              wr_r_en_q, wr_r_en_d;
    logic              wr_s_en_q, wr_s_en_d;
    logic [R_AW-1:0]   wr_r_addr_q, wr_r_addr_d;
    logic [S_AW-1:0]   wr_s_addr_q, wr_s_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              start_dly_q, start_dly_d;
    logic              me_start_q, me_start_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    me_result_t        res_q, res_d;
    logic              res_valid_q, res_valid_d;
    logic              accept;

    assign accept = pix_valid & pix_ready_q;

    // Next-state logic: load sequencing, start handshake, timeout, result capture.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        wr_r_en_d   = 1'b0;
        wr_s_en_d   = 1'b0;
        wr_r_addr_d = wr_r_addr_q;
        wr_s_addr_d = wr_s_addr_q;
        wr_data_d   = wr_data_q;
        start_dly_d = start_dly_q;
        me_start_d  = me_start_q;
        tmo_d       = tmo_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;

        case (state_q)
            ST_IDLE: begin
                // Pixels before a start-of-frame are dropped without a write.
                if (accept && pix_sof) begin
                    wr_r_en_d   = 1'b1;
                    wr_r_addr_d = '0;
                    wr_data_d   = pix_data;
                    idx_d       = S_AW'(1);
                    state_d     = ST_LOAD_R;
                end
            end

            ST_LOAD_R, ST_LOAD_S: begin
                if (accept) begin
                    wr_data_d = pix_data;
                    if (pix_sof) begin
                        // A fresh frame restarts the load; stale data is overwritten.
                        wr_r_en_d   = 1'b1;
                        wr_r_addr_d = '0;
                        idx_d       = S_AW'(1);
                        state_d     = ST_LOAD_R;
                    end else if (state_q == ST_LOAD_R) begin
                        wr_r_en_d   = 1'b1;
                        wr_r_addr_d = idx_q[R_AW-1:0];
                        if (idx_q == R_LAST) begin
                            idx_d   = '0;
                            state_d = ST_LOAD_S;
                        end else begin
                            idx_d = idx_q + S_AW'(1);
                        end
                    end else begin
                        wr_s_en_d   = 1'b1;
                        wr_s_addr_d = idx_q;
                        if (idx_q == S_LAST) begin
                            idx_d   = '0;
                            state_d = ST_RUN;
                        end else begin
                            idx_d = idx_q + S_AW'(1);
                        end
                    end
                end
            end

            ST_RUN: begin
                if (!me_start_q) begin
                    // One spare cycle so the final S write lands before start.
                    if (start_dly_q) begin
                        me_start_d  = 1'b1;
                        start_dly_d = 1'b0;
                        tmo_d       = TMO_LOAD;
                    end else begin
                        start_dly_d = 1'b1;
                    end
                end else if (me_completed) begin
                    res_d.best_dist = me_best_dist;
                    res_d.motion_x  = me_motion_x;
                    res_d.motion_y  = me_motion_y;
                    res_d.found     = (me_best_dist != NOT_FOUND);
                    res_d.timeout   = 1'b0;
                    me_start_d      = 1'b0;
                    res_valid_d     = 1'b1;
                    state_d         = ST_OUTPUT;
                end else if (tmo_q == '0) begin
                    res_d.best_dist = NOT_FOUND;
                    res_d.motion_x  = '0;
                    res_d.motion_y  = '0;
                    res_d.found     = 1'b0;
                    res_d.timeout   = 1'b1;
                    me_start_d      = 1'b0;
                    res_valid_d     = 1'b1;
                    state_d         = ST_OUTPUT;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end

            ST_OUTPUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        pix_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD_R) ||
                      (state_d == ST_LOAD_S);
    end

    // State and output registers, all cleared by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            pix_ready_q <= 1'b0;
            wr_r_en_q   <= 1'b0;
            wr_s_en_q   <= 1'b0;
            wr_r_addr_q <= '0;
            wr_s_addr_q <= '0;
            wr_data_q   <= '0;
            start_dly_q <= 1'b0;
            me_start_q  <= 1'b0;
            tmo_q       <= '0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pix_ready_q <= pix_ready_d;
            wr_r_en_q   <= wr_r_en_d;
            wr_s_en_q   <= wr_s_en_d;
            wr_r_addr_q <= wr_r_addr_d;
            wr_s_addr_q <= wr_s_addr_d;
            wr_data_q   <= wr_data_d;
            start_dly_q <= start_dly_d;
            me_start_q  <= me_start_d;
            tmo_q       <= tmo_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign pix_ready     = pix_ready_q;
    assign wr_r_en       = wr_r_en_q;
    assign wr_r_addr     = wr_r_addr_q;
    assign wr_s_en       = wr_s_en_q;
    assign wr_s_addr     = wr_s_addr_q;
    assign wr_data       = wr_data_q;
    assign me_start      = me_start_q;
    assign res_valid     = res_valid_q;
    assign res_best_dist = res_q.best_dist;
    assign res_motion_x  = res_q.motion_x;
    assign res_motion_y  = res_q.motion_y;
    assign res_found     = res_q.found;
    assign res_timeout   = res_q.timeout;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_me_window_loader.sv
// Randomized bench for the window loader with a frame-level write model.
module tb_me_window_loader;

    localparam int RUN_TIMEOUT = 4200;
    localparam int BLOCK_PIX   = 1280;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       pix_valid = 1'b0;
    logic       pix_sof = 1'b0;
    logic [7:0] pix_data = 8'h00;
    logic       pix_ready;
    logic       wr_r_en;
    logic [7:0] wr_r_addr;
    logic       wr_s_en;
    logic [9:0] wr_s_addr;
    logic [7:0] wr_data;
    logic       me_start;
    logic       me_completed = 1'b0;
    logic [7:0] me_best_dist = 8'h00;
    logic [3:0] me_motion_x = 4'h0;
    logic [3:0] me_motion_y = 4'h0;
    logic       res_valid;
    logic       res_ready = 1'b0;
    logic [7:0] res_best_dist;
    logic [3:0] res_motion_x;
    logic [3:0] res_motion_y;
    logic       res_found;
    logic       res_timeout;
    logic       busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit         is_s;
        int         addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];

    logic [7:0] exp_bd;
    int         exp_mx;
    int         exp_my;
    logic       exp_found;
    logic       exp_tmo;

    me_window_loader #(.DATA_W(8), .RUN_TIMEOUT(RUN_TIMEOUT)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .pix_valid     (pix_valid),
        .pix_sof       (pix_sof),
        .pix_data      (pix_data),
        .pix_ready     (pix_ready),
        .wr_r_en       (wr_r_en),
        .wr_r_addr     (wr_r_addr),
        .wr_s_en       (wr_s_en),
        .wr_s_addr     (wr_s_addr),
        .wr_data       (wr_data),
        .me_start      (me_start),
        .me_completed  (me_completed),
        .me_best_dist  (me_best_dist),
        .me_motion_x   (me_motion_x),
        .me_motion_y   (me_motion_y),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_best_dist (res_best_dist),
        .res_motion_x  (res_motion_x),
        .res_motion_y  (res_motion_y),
        .res_found     (res_found),
        .res_timeout   (res_timeout),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Every memory write must match the next one the frame model predicts.
    always @(negedge clock) begin : wr_monitor
        wr_t e;
        if (reset_n && (wr_r_en || wr_s_en)) begin
            check_eq("wr_one_en", 32'(wr_r_en & wr_s_en), 32'd0);
            if (exp_q.size() == 0) begin
                check_eq("wr_extra", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("wr_kind", 32'(wr_s_en), 32'(e.is_s));
                check_eq("wr_addr", wr_s_en ? 32'(wr_s_addr) : 32'(wr_r_addr), 32'(e.addr));
                check_eq("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
    end

    task automatic check_res(input string tag);
        check_eq({tag, "_bd"},  32'(res_best_dist), 32'(exp_bd));
        check_eq({tag, "_mx"},  32'(int'($signed(res_motion_x))), 32'(exp_mx));
        check_eq({tag, "_my"},  32'(int'($signed(res_motion_y))), 32'(exp_my));
        check_eq({tag, "_fnd"}, 32'(res_found), 32'(exp_found));
        check_eq({tag, "_tmo"}, 32'(res_timeout), 32'(exp_tmo));
    endtask

    // Streams three stray pixels, an optional aborted prefix, then a full frame.
    // Expected writes come from frame position: position p < 256 is R[p],
    // otherwise S[p-256]; a start-of-frame pixel resets the position to 0.
    task automatic load_block(input int restart_at, input bit gaps, input bit rnd);
        bit         sofs[$];
        logic [7:0] dats[$];
        int         pos;
        int         guard;
        wr_t        w;
        for (int i = 0; i < 3; i++) begin
            sofs.push_back(1'b0);
            dats.push_back(8'($urandom));
        end
        for (int i = 0; i < restart_at; i++) begin
            sofs.push_back(i == 0);
            dats.push_back(8'($urandom));
        end
        for (int i = 0; i < BLOCK_PIX; i++) begin
            sofs.push_back(i == 0);
            dats.push_back(rnd ? 8'($urandom) : 8'(i & 255));
        end
        pos = -1;
        for (int i = 0; i < sofs.size(); i++) begin
            if (sofs[i]) pos = 0;
            else if (pos >= 0) pos++;
            if (pos >= 0) begin
                w.is_s = (pos >= 256);
                w.addr = (pos >= 256) ? pos - 256 : pos;
                w.data = dats[i];
                exp_q.push_back(w);
            end
        end
        for (int i = 0; i < sofs.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                pix_valid = 1'b0;
                tick();
            end
            pix_valid = 1'b1;
            pix_sof   = sofs[i];
            pix_data  = dats[i];
            guard = 0;
            while (!pix_ready && guard < 20) begin
                tick();
                guard++;
            end
            if (guard >= 20) begin
                check_eq("pix_ready_stuck", 32'd0, 32'd1);
                $display("test done: total=%0d bad=%0d", total, bad);
                $fatal(1, "loader stopped accepting pixels");
            end
            tick();
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        check_eq("rdy_after_load", 32'(pix_ready), 32'd0);
        check_eq("start_e0", 32'(me_start), 32'd0);
        tick();
        check_eq("start_e1", 32'(me_start), 32'd0);
        tick();
        check_eq("start_e2", 32'(me_start), 32'd1);
        check_eq("wr_missing", 32'(exp_q.size()), 32'd0);
    endtask

    // Called in the first cycle start is high; pulses completed after 'after' cycles.
    task automatic run_complete(input int after, input logic [7:0] bd,
                                input logic [3:0] mx, input logic [3:0] my);
        repeat (after) tick();
        check_eq("start_held", 32'(me_start), 32'd1);
        check_eq("no_res_early", 32'(res_valid), 32'd0);
        me_completed = 1'b1;
        me_best_dist = bd;
        me_motion_x  = mx;
        me_motion_y  = my;
        tick();
        me_completed = 1'b0;
        me_best_dist = ~bd;
        me_motion_x  = ~mx;
        me_motion_y  = ~my;
        exp_bd    = bd;
        exp_mx    = int'($signed(mx));
        exp_my    = int'($signed(my));
        exp_found = (bd != 8'hFF);
        exp_tmo   = 1'b0;
        check_eq("cmp_valid", 32'(res_valid), 32'd1);
        check_eq("cmp_start", 32'(me_start), 32'd0);
        check_eq("cmp_rdy", 32'(pix_ready), 32'd0);
        check_res("cmp");
    endtask

    task automatic drain(input int hold);
        res_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            tick();
            check_eq("bp_valid", 32'(res_valid), 32'd1);
            check_res("bp");
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check_eq("hs_valid", 32'(res_valid), 32'd0);
        check_eq("hs_busy", 32'(busy), 32'd0);
        check_eq("hs_rdy", 32'(pix_ready), 32'd1);
        check_res("hs_keep");
    endtask

    initial begin : watchdog
        #1500000;
        check_eq("watchdog", 32'd0, 32'd1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation time limit");
    end

    initial begin : stim
        int cnt;
        logic [7:0] rbd;

        // Reset values.
        tick();
        tick();
        check_eq("rst_rdy", 32'(pix_ready), 32'd0);
        check_eq("rst_start", 32'(me_start), 32'd0);
        check_eq("rst_valid", 32'(res_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_wren", 32'({wr_r_en, wr_s_en}), 32'd0);
        check_eq("rst_res", 32'({res_best_dist, res_motion_x, res_motion_y, res_found, res_timeout}), 32'd0);
        reset_n = 1'b1;
        tick();
        check_eq("rel_rdy", 32'(pix_ready), 32'd1);

        // Ramp-data frame, completion, 10 cycles of backpressure.
        load_block(-1, 1'b0, 1'b0);
        run_complete(4112, 8'h05, 4'hD, 4'h3);
        check_eq("mx_neg3", 32'(int'($signed(res_motion_x))), 32'hFFFF_FFFD);
        drain(10);

        // Restart on the 101st R pixel, gappy random stream.
        load_block(100, 1'b1, 1'b1);
        rbd = 8'($urandom_range(0, 254));
        run_complete($urandom_range(0, 3000), rbd, 4'($urandom), 4'($urandom));
        drain($urandom_range(0, 3));

        // Completion on the first start cycle reporting not-found.
        load_block(-1, 1'b1, 1'b1);
        run_complete(0, 8'hFF, 4'($urandom), 4'($urandom));
        drain(0);

        // Timeout, then a late completion while the result is held.
        load_block(-1, 1'b0, 1'b1);
        cnt = 0;
        while (me_start && cnt < RUN_TIMEOUT + 10) begin
            tick();
            cnt++;
        end
        check_eq("tmo_cycles", 32'(cnt), 32'(RUN_TIMEOUT));
        exp_bd    = 8'hFF;
        exp_mx    = 0;
        exp_my    = 0;
        exp_found = 1'b0;
        exp_tmo   = 1'b1;
        check_eq("tmo_valid", 32'(res_valid), 32'd1);
        check_res("tmo");
        me_completed = 1'b1;
        me_best_dist = 8'h05;
        me_motion_x  = 4'h1;
        me_motion_y  = 4'h2;
        tick();
        me_completed = 1'b0;
        check_res("late_cmp");
        drain(2);

        // Reset in the middle of a run.
        load_block(-1, 1'b0, 1'b1);
        repeat (1999) tick();
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("mid_start", 32'(me_start), 32'd0);
        check_eq("mid_busy", 32'(busy), 32'd0);
        check_eq("mid_rdy", 32'(pix_ready), 32'd0);
        check_eq("mid_valid", 32'(res_valid), 32'd0);
        tick();
        reset_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (res_valid || me_start) cnt++;
        end
        check_eq("mid_no_res", 32'(cnt), 32'd0);
        check_eq("mid_rdy_after", 32'(pix_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/me_window_loader.md
Name: me_window_loader

Overview:
- Upstream feeder for the motion estimator top. Accepts a raster pixel stream: 256 reference pixels (16x16 block), then 1024 search-window pixels (32x32).
- Writes the reference pixels into the R memory and the search-window pixels into the S memory, then holds start to the estimator until it reports completed.
- Captures BestDist/motionX/motionY and presents one result per block on a valid/ready output, with a run timeout as a safety net.

Parameters:
- DATA_W, 8, pixel width
- R_PIXELS, 256, reference block pixel count (R address width 8)
- S_PIXELS, 1024, search window pixel count (S address width 10)
- RUN_TIMEOUT, 4200, max cycles start may be held before forcing a timeout result

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- pix_valid  in  1  input pixel valid
- pix_sof  in  1  marks first reference pixel of a block set
- pix_data  in  DATA_W  input pixel
- pix_ready  out  1  loader can accept a pixel
- wr_r_en  out  1  R memory write enable
- wr_r_addr  out  8  R memory write address
- wr_s_en  out  1  S memory write enable
- wr_s_addr  out  10  S memory write address
- wr_data  out  DATA_W  write data, shared by both memories
- me_start  out  1  start to estimator, level, held during run
- me_completed  in  1  estimator done
- me_best_dist  in  8  estimator BestDist
- me_motion_x  in  4  estimator motionX, two's complement
- me_motion_y  in  4  estimator motionY, two's complement
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_best_dist  out  8  captured BestDist
- res_motion_x  out  4  captured motionX, signed -8..7
- res_motion_y  out  4  captured motionY, signed -8..7
- res_found  out  1  captured BestDist != 8'hFF
- res_timeout  out  1  result produced by timeout
- busy  out  1  state != IDLE

Behaviour:
- Transfer: a pixel is accepted when pix_valid & pix_ready.
- States: IDLE, LOAD_R, LOAD_S, RUN, OUTPUT.
- Reset (async, any state): state IDLE; all outputs 0, including pix_ready, me_start, res_*, and write enables. Counters cleared.
- pix_ready = 1 in IDLE, LOAD_R and LOAD_S only; 0 otherwise.
- IDLE:
  - Accepted pixel with pix_sof=1 becomes R index 0; go to LOAD_R with index counter at 1.
  - Accepted pixels with pix_sof=0 are discarded; no write is issued.
- LOAD_R / LOAD_S:
  - Each accepted pixel is written at the current index. Index increments.
  - After R index 255, switch to LOAD_S at index 0. After S index 1023, go to RUN.
  - pix_sof=1 on an accepted pixel in either load state restarts the load: the pixel becomes R index 0 and the state returns to LOAD_R. Partially written data is simply overwritten.
- Write timing: wr_*_en, wr_*_addr and wr_data are registered, appearing the cycle after the accept. wr_*_en is high for exactly one cycle per accepted pixel, and never both enables in the same cycle.
- RUN:
  - me_start rises 2 cycles after the final S pixel is accepted, so the last write lands first.
  - me_start stays high until me_completed is sampled 1.
  - On that edge, capture me_best_dist, me_motion_x and me_motion_y. Set res_found = (me_best_dist != 8'hFF) and res_timeout = 0.
  - Next cycle: me_start = 0, res_valid = 1, state OUTPUT.
- Timeout:
  - A 13-bit cycle counter runs while me_start = 1.
  - When it reaches RUN_TIMEOUT without completed: res_best_dist = 8'hFF, motions = 0, res_found = 0, res_timeout = 1; go to OUTPUT with me_start = 0.
  - If completed and timeout occur in the same cycle, completed wins.
- OUTPUT:
  - res_* are held stable while res_valid & !res_ready.
  - On res_valid & res_ready: res_valid = 0 next cycle, state IDLE. Captured values remain on res_* until the next capture.
- me_completed is ignored outside RUN. res_ready is ignored when res_valid = 0.
- Minimum turnaround: me_start low for at least 1 cycle between runs (guaranteed by the load phase).

Decomposition:
- Package me_pkg:
  - state enum (IDLE, LOAD_R, LOAD_S, RUN, OUTPUT)
  - constants R_PIXELS, S_PIXELS, R_AW = 8, S_AW = 10, NOT_FOUND = 8'hFF
  - packed struct me_result_t {best_dist, motion_x, motion_y, found, timeout}
- Single module; no sub-module is warranted. The index counter and the timeout counter are inline.

Test Plan:
- Reset behaviour: reset_n low, then released → all outputs 0 during reset, pix_ready = 1 one cycle after release. Reset asserted mid-RUN at cycle 2000 → me_start = 0 and state IDLE immediately; no result is produced.
- Full load: 1280 pixels with pix_sof on the first, data = index & 8'hFF, pix_valid always high → wr_r_addr 0..255 and wr_s_addr 0..1023 each exactly once with matching data; me_start rises 2 cycles after the last accept; pix_ready = 0 thereafter.
- Completion: me_completed pulsed after 4112 start cycles with best_dist 8'h05, mx 4'hD, my 4'h3 → res_valid = 1 next cycle, res_motion_x = -3, res_motion_y = 3, res_found = 1, res_timeout = 0, me_start = 0.
- Backpressure: res_ready held low 10 cycles, then high → res_* stable for all 10 cycles; one handshake; back to IDLE with pix_ready = 1.
- Restart: pix_sof reasserted on the 101st R pixel → the next write is wr_r_addr = 0 with that pixel's data; the full load then completes normally.
- Timeout: me_completed never asserted → exactly RUN_TIMEOUT cycles after start: res_best_dist = 8'hFF, res_found = 0, res_timeout = 1. A late me_completed in OUTPUT is ignored.
